// File: rtl/ast_response_router.sv
// Response router: records granted requester IDs in order and steers the
// shared response stream back to the requester that owns the head tag.
module ast_response_router #(
    parameter int switch_bits = 3,
    parameter int data_width  = 132,
    parameter int tag_depth   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_grant_valid,
    input  logic [switch_bits-1:0]      i_grant_id,
    output logic                        o_grant_ready,
    input  logic                        i_resp_valid,
    input  logic [data_width-1:0]       i_resp_data,
    output logic                        o_resp_ready,
    output logic [(1<<switch_bits)-1:0] o_out_valid,
    output logic [data_width-1:0]       o_out_data,
    input  logic [(1<<switch_bits)-1:0] i_out_ready,
    output logic [$clog2(tag_depth):0]  o_outstanding
);

    localparam int N  = 1 << switch_bits;
    localparam int PW = $clog2(tag_depth);
    localparam int CW = PW + 1;

    logic [switch_bits-1:0] r_tags [tag_depth];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_hold_valid;
    logic [switch_bits-1:0] r_hold_id;
    logic [data_width-1:0]  r_hold_data;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_out_fire;
    logic [switch_bits-1:0] w_head_tag;

    assign w_full     = (r_count == CW'(tag_depth));
    assign w_empty    = (r_count == '0);
    assign w_head_tag = r_tags[r_rptr];

    // Full blocks grants even when a pop happens in the same cycle.
    assign o_grant_ready = !w_full;
    assign w_push        = i_grant_valid && !w_full;

    assign w_out_fire   = r_hold_valid && i_out_ready[r_hold_id];
    assign o_resp_ready = !w_empty && (!r_hold_valid || w_out_fire);
    assign w_pop        = i_resp_valid && o_resp_ready;

    assign o_out_valid   = r_hold_valid ? (N'(1) << r_hold_id) : '0;
    assign o_out_data    = r_hold_data;
    assign o_outstanding = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_tags[r_wptr] <= i_grant_id;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Accepting a new response replaces the held one when it fires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_valid <= 1'b0;
            r_hold_id    <= '0;
            r_hold_data  <= '0;
        end else if (w_pop) begin
            r_hold_valid <= 1'b1;
            r_hold_id    <= w_head_tag;
            r_hold_data  <= i_resp_data;
        end else if (w_out_fire) begin
            r_hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ast_response_router.sv
// Bench for ast_response_router: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ast_response_router;

    localparam int SB = 3;
    localparam int DW = 132;
    localparam int TD = 4;
    localparam int N  = 1 << SB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          gv = 1'b0;
    logic [SB-1:0] gid = '0;
    logic          gr;
    logic          rv = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rr;
    logic [N-1:0]  ov;
    logic [DW-1:0] od;
    logic [N-1:0]  ordy = '0;
    logic [2:0]    outst;

    int checks = 0;
    int errors = 0;

    int            tagq[$];
    bit            m_known = 0;
    bit            m_hv = 0;
    int            m_hid = 0;
    logic [DW-1:0] m_hd = '0;

    always #5 clk = ~clk;

    ast_response_router #(
        .switch_bits(SB),
        .data_width (DW),
        .tag_depth  (TD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_grant_valid(gv),
        .i_grant_id   (gid),
        .o_grant_ready(gr),
        .i_resp_valid (rv),
        .i_resp_data  (rdata),
        .o_resp_ready (rr),
        .o_out_valid  (ov),
        .o_out_data   (od),
        .i_out_ready  (ordy),
        .o_outstanding(outst)
    );

    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        bit exp_gr;
        bit exp_fire;
        bit exp_rr;
        logic [N-1:0] exp_ov;
        exp_gr   = (tagq.size() != TD);
        exp_fire = m_hv && ordy[m_hid];
        exp_rr   = (tagq.size() != 0) && (!m_hv || exp_fire);
        exp_ov   = '0;
        if (m_hv) exp_ov[m_hid] = 1'b1;
        chk("grant_ready", DW'(gr), DW'(exp_gr));
        chk("resp_ready", DW'(rr), DW'(exp_rr));
        chk("out_valid", DW'(ov), DW'(exp_ov));
        chk("out_data", od, m_hd);
        chk("outstanding", DW'(outst), DW'(tagq.size()));
    endtask

    task automatic update_model();
        bit push;
        bit pop;
        bit fire;
        if (rst) begin
            tagq.delete();
            m_hv    = 0;
            m_hd    = '0;
            m_known = 1;
            return;
        end
        fire = m_hv && ordy[m_hid];
        push = gv && (tagq.size() != TD);
        pop  = rv && (tagq.size() != 0) && (!m_hv || fire);
        if (pop) begin
            m_hv  = 1;
            m_hid = tagq.pop_front();
            m_hd  = rdata;
        end else if (fire) begin
            m_hv = 0;
        end
        if (push) tagq.push_back(int'(gid));
    endtask

    task automatic cycle();
        @(negedge clk);
        if (m_known) check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        // Reset and in-order routing of ids 5,2,7
        rst = 1; cycle(); rst = 0;
        chk("rst_outstanding", DW'(outst), DW'(0));
        chk("rst_grant_ready", DW'(gr), DW'(1));
        chk("rst_out_valid", DW'(ov), DW'(0));
        chk("rst_out_data", od, DW'(0));
        gv = 1;
        gid = 3'd5; cycle();
        gid = 3'd2; cycle();
        gid = 3'd7; cycle();
        gv = 0; rv = 1; ordy = '1;
        rdata = DW'(12'hA); cycle();
        chk("seq_ov0", DW'(ov), DW'(8'h20));
        chk("seq_od0", od, DW'(12'hA));
        rdata = DW'(12'hB); cycle();
        chk("seq_ov1", DW'(ov), DW'(8'h04));
        chk("seq_od1", od, DW'(12'hB));
        rdata = DW'(12'hC); cycle();
        chk("seq_ov2", DW'(ov), DW'(8'h80));
        chk("seq_od2", od, DW'(12'hC));
        rv = 0; cycle();
        chk("seq_drained", DW'(outst), DW'(0));

        // Fill to full, held 5th grant, pop with simultaneous grant
        gv = 1;
        for (int i = 0; i < 4; i++) begin
            gid = SB'(i + 1); cycle();
        end
        chk("full_gr", DW'(gr), DW'(0));
        chk("full_outst", DW'(outst), DW'(4));
        gid = 3'd6; cycle();
        chk("held_outst", DW'(outst), DW'(4));
        rv = 1; rdata = DW'(8'h11); #1;
        chk("full_pop_gr", DW'(gr), DW'(0));
        cycle();
        chk("pop_outst", DW'(outst), DW'(3));
        chk("pop_gr", DW'(gr), DW'(1));
        chk("pop_ov", DW'(ov), DW'(8'h02));
        gv = 0;
        for (int i = 0; i < 3; i++) begin
            rdata = rnd_data(); cycle();
        end
        rv = 0; cycle();

        // Backpressure on requester 3
        gv = 1; gid = 3'd3; cycle();
        gid = 3'd6; cycle();
        gv = 0; rv = 1; rdata = DW'(8'h55); ordy = 8'hF7; cycle();
        rdata = DW'(8'h66);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ov", DW'(ov), DW'(8'h08));
            chk("bp_od", od, DW'(8'h55));
            chk("bp_rr", DW'(rr), DW'(0));
            cycle();
        end
        ordy = '1; #1;
        chk("bp_release_rr", DW'(rr), DW'(1));
        cycle();
        chk("bp_next_ov", DW'(ov), DW'(8'h40));
        chk("bp_next_od", od, DW'(8'h66));
        rv = 0; cycle();

        // Orphan response stalls until a grant arrives
        rv = 1; rdata = DW'(8'h77);
        for (int i = 0; i < 4; i++) begin
            chk("orphan_rr", DW'(rr), DW'(0));
            chk("orphan_ov", DW'(ov), DW'(0));
            cycle();
        end
        gv = 1; gid = 3'd1; cycle();
        gv = 0; cycle();
        chk("orphan_ov_after", DW'(ov), DW'(8'h02));
        chk("orphan_od_after", od, DW'(8'h77));
        rv = 0; cycle();

        // Reset mid-operation
        gv = 1;
        gid = 3'd4; cycle();
        gid = 3'd5; cycle();
        gid = 3'd6; cycle();
        gv = 0; rv = 1; ordy = '0; cycle();
        chk("pre_rst_outst", DW'(outst), DW'(2));
        rv = 0; rst = 1; cycle(); rst = 0;
        chk("mid_rst_ov", DW'(ov), DW'(0));
        chk("mid_rst_outst", DW'(outst), DW'(0));
        chk("mid_rst_gr", DW'(gr), DW'(1));
        ordy = '1; gv = 1; gid = 3'd0; cycle();
        gv = 0; rv = 1; rdata = DW'(8'h99); cycle();
        chk("post_rst_ov", DW'(ov), DW'(8'h01));
        chk("post_rst_od", od, DW'(8'h99));
        rv = 0; cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            gv    = ($urandom_range(0, 2) != 0);
            gid   = SB'($urandom);
            rv    = ($urandom_range(0, 3) != 0);
            rdata = rnd_data();
            ordy  = ($urandom_range(0, 2) != 0) ? '1 : N'($urandom);
            cycle();
        end
        rst = 0; gv = 0; rv = 0; cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ast_response_router.md
Name: ast_response_router

Overview:
- Return-path companion to the access scheduler tree.
- The tree merges up to N requesters into one serviced stream. This block records the ID of each granted requester in order, then routes the single shared response stream back to the originating requester.
- Sits between the shared memory/interconnect response port and the per-requester response inputs.
- Responses are assumed to return in grant order.

Parameters:
- switch_bits, 3, log2 of requester count; N = 1 << switch_bits.
- data_width, 132, response payload width; matches the scheduler tree data width.
- tag_depth, 4, maximum outstanding grants; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- grant_valid  in  1  scheduler issued a grant this cycle.
- grant_id  in  switch_bits  index of the granted requester.
- grant_ready  out  1  tag FIFO can accept a grant.
- resp_valid  in  1  shared response available.
- resp_data  in  data_width  shared response payload.
- resp_ready  out  1  router accepts the response this cycle.
- out_valid  out  N  one-hot; bit i means a response is presented to requester i.
- out_data  out  data_width  response payload, broadcast to all requesters.
- out_ready  in  N  per-requester ready.
- outstanding  out  log2(tag_depth)+1  current tag FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO pointers and count cleared.
  - Output register invalid: out_valid=0, out_data=0.
  - outstanding=0, grant_ready=1.
  - Reset mid-operation discards all tags and any held response with no handshake.
- Tag FIFO:
  - Circular buffer of tag_depth entries, each switch_bits wide.
  - Read/write pointers are log2(tag_depth) bits and wrap naturally; count is kept separately.
  - grant_ready = (count != tag_depth). There is no push-while-full bypass, even if a pop occurs in the same cycle.
  - Push occurs when grant_valid && grant_ready; grant_id is written at the write pointer.
  - Grants with grant_ready=0 are ignored; the scheduler must hold them.
- Output register: one entry holding {hold_valid, hold_id, hold_data}.
  - out_valid = hold_valid ? (1 << hold_id) : 0.
  - out_data = hold_data.
  - out_fire = hold_valid && out_ready[hold_id]. out_ready bits of other requesters are ignored.
- Response accept:
  - resp_ready = (count != 0) && (!hold_valid || out_fire). Not dependent on resp_valid.
  - On resp_valid && resp_ready:
    - hold_data <= resp_data, hold_id <= tag at head, hold_valid <= 1.
    - Tag is popped.
  - Else if out_fire: hold_valid <= 0.
- Latency:
  - Response accepted at edge T appears on out_valid/out_data in the cycle after T.
  - A grant pushed at edge T can first match a response accepted at edge T+1. Tags are not forwarded in the same cycle.
- Throughput: one response per cycle while out_ready[head] stays high (pipelined replace on out_fire).
- Simultaneous push and pop: count unchanged, both pointers advance. Permitted whenever not full before the edge.
- Empty FIFO with resp_valid=1: resp_ready=0 and the response stalls indefinitely. An orphan response is a system error; the block does not drop it.
- Backpressure: held data and one-hot are stable while out_ready[hold_id]=0. This is required for verification.
- outstanding equals count, updated at the clock edge.
- The FSM is implicit in (count, hold_valid). States:
  - IDLE: count=0, !hold.
  - ARMED: count>0, !hold.
  - HOLD: hold, count=0.
  - STREAM: hold, count>0.
- Transitions follow the push, pop and out_fire rules above.

Test Plan:
- Reset, then grants ids 5,2,7 on consecutive cycles. Responses 0xA,0xB,0xC with out_ready all-ones → out_valid = 0x20,0x04,0x80 on successive cycles carrying 0xA,0xB,0xC; outstanding returns to 0.
- Five grants with tag_depth=4 and no responses → grant_ready drops after the 4th push; the 5th is held. outstanding=4. One response popped → grant_ready=1 the next cycle.
- Grant id 3, response 0x55, out_ready[3]=0 for 3 cycles with other bits high → out_valid=0x08 and out_data=0x55 held stable, resp_ready=0 for a queued second response. Releasing out_ready[3] → second response loads the same cycle.
- resp_valid=1 with FIFO empty for 4 cycles → resp_ready=0 throughout, out_valid=0. Grant id 1 arrives → response accepted the following cycle, out_valid=0x02.
- FIFO full (4) with simultaneous grant_valid and response pop → grant_ready=0 that cycle, the grant is not pushed, and outstanding=3 afterward.
- rst asserted while outstanding=2 and hold_valid=1 → next cycle out_valid=0, outstanding=0, grant_ready=1. A subsequent grant 0 plus response routes correctly to bit 0.
